// File: rtl/arb_request_master.sv
// rtl/arb_request_master.sv - per-channel job queue and REQ/GNT burst requester (optional GNT_TIMEOUT_EN watchdog)
module arb_request_master #(
    parameter int N_CH      = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] push,
    output logic [N_CH-1:0] REQ,
    input  logic [N_CH-1:0] GNT,
    output logic [N_CH-1:0] beat_valid,
    output logic [N_CH-1:0] beat_last,
    output logic [N_CH-1:0] busy,
    output logic [N_CH-1:0] ovf,
    output logic            gnt_err,
    output logic [N_CH-1:0] starve
);

    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE_S,
        REQ_S,
        XFER_S,
        GAP_S
    } state_t;

    logic [N_CH-1:0] gnt_idle;
    logic            gnt_multi;

    // More than one grant bit at once can never come from a legal arbiter.
    assign gnt_multi = (GNT & (GNT - N_CH'(1))) != '0;

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            state_t             state_q, state_d;
            logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
            logic [CNT_W-1:0]   pend_q;
            logic               ovf_q;
            logic               active;
            logic               beat;
            logic               last;
            logic               full;

            assign active        = (state_q == REQ_S) || (state_q == XFER_S);
            assign beat          = active && GNT[g];
            assign last          = beat && (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
            assign full          = &pend_q;
            assign REQ[g]        = active;
            assign beat_valid[g] = beat;
            assign beat_last[g]  = last;
            assign busy[g]       = (pend_q != '0) || (state_q != IDLE_S);
            assign ovf[g]        = ovf_q;
            assign gnt_idle[g]   = GNT[g] && (state_q == IDLE_S);

            // Channel state and beat position registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q    <= IDLE_S;
                    beat_cnt_q <= '0;
                end else begin
                    state_q    <= state_d;
                    beat_cnt_q <= beat_cnt_d;
                end
            end

            // Next state: a beat only happens on granted cycles, so preemption simply holds.
            always_comb begin
                state_d    = state_q;
                beat_cnt_d = beat_cnt_q;
                case (state_q)
                    IDLE_S: begin
                        if (pend_q != '0) state_d = REQ_S;
                    end
                    REQ_S, XFER_S: begin
                        if (beat) begin
                            if (last) begin
                                state_d    = GAP_S;
                                beat_cnt_d = '0;
                            end else begin
                                state_d    = XFER_S;
                                beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                            end
                        end
                    end
                    GAP_S:   state_d = IDLE_S;
                    default: state_d = IDLE_S;
                endcase
            end

            // Pending-job counter; a job is retired by its final beat, so a push then is never lost.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    pend_q <= '0;
                    ovf_q  <= 1'b0;
                end else if (push[g] && !last) begin
                    if (full) ovf_q  <= 1'b1;
                    else      pend_q <= pend_q + CNT_W'(1);
                end else if (!push[g] && last) begin
                    pend_q <= pend_q - CNT_W'(1);
                end
            end

`ifdef GNT_TIMEOUT_EN
            localparam int WAIT_W = $clog2(TIMEOUT + 1);
            logic [WAIT_W-1:0] wait_q;
            logic              starve_q;

            assign starve[g] = starve_q;

            // Starvation watchdog: counts requested-but-ungranted cycles, saturating at TIMEOUT.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wait_q   <= '0;
                    starve_q <= 1'b0;
                end else if (!active || GNT[g]) begin
                    wait_q <= '0;
                end else begin
                    if (wait_q != WAIT_W'(TIMEOUT)) wait_q <= wait_q + WAIT_W'(1);
                    if (wait_q == WAIT_W'(TIMEOUT - 1)) starve_q <= 1'b1;
                end
            end
`else
            // Without the watchdog the threshold is meaningless; the flag is constant zero.
            assign starve[g] = (TIMEOUT < 0);
`endif
        end
    endgenerate

    // Sticky grant protocol error: multiple grants, or a grant to an idle channel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        gnt_err <= 1'b0;
        else if (gnt_multi || |gnt_idle)  gnt_err <= 1'b1;
    end

endmodule
